trng_pool_manager: RTL
======================

TRNG_POOL_MANAGER -- requirements
Module: trng_pool_manager

Interface
REQ-001 Parameter TRNG_A_WIDTH, default 64, width of the address-scrambling TRNG word.
REQ-002 Parameter TRNG_D_WIDTH, default 32, width of the data-masking TRNG word.
REQ-003 Parameter NUM_CH, default 4, number of independent consumer channels.
REQ-004 Parameter DEPTH, default 8, power of two >= 2, prefetch buffer entries.
REQ-005 clk  in  1  clock; all state SHALL update on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 src_valid  in  1  entropy source holds a valid {a,d} pair.
REQ-008 src_a  in  TRNG_A_WIDTH  source A word.
REQ-009 src_d  in  TRNG_D_WIDTH  source D word.
REQ-010 src_ready  out  1  manager accepts pair this cycle; SHALL equal "buffer not full".
REQ-011 dcr  in  NUM_CH  per-channel single-cycle refresh request.
REQ-012 trng_a_out  out  NUM_CH*TRNG_A_WIDTH  per-channel A register; channel i at slice i.
REQ-013 trng_d_out  out  NUM_CH*TRNG_D_WIDTH  per-channel D register; channel i at slice i.
REQ-014 upd  out  NUM_CH  one-cycle pulse; channel i output registers were loaded.
REQ-015 pending  out  NUM_CH  channel has an unserved refresh request.
REQ-016 level  out  $clog2(DEPTH)+1  buffer occupancy.
REQ-017 underrun  out  1  sticky; set when any dcr arrives while buffer empty.

Function
REQ-018 Pair SHALL be written to buffer when src_valid && src_ready; FIFO order.
REQ-019 dcr[i]=1 SHALL set pending[i]; pending[i] SHALL stay set until channel i is served.
REQ-020 Each cycle at most one channel SHALL be served: lowest index i with pending[i] (including dcr[i] arriving the same cycle), provided buffer not empty.
REQ-021 Serving i SHALL pop the head pair, load it into channel i registers, clear pending[i], pulse upd[i] on the next cycle edge; latency dcr -> updated output = 1 cycle when buffer non-empty and no higher-priority pending.
REQ-022 Unserved channels SHALL hold their output registers unchanged.
REQ-023 Simultaneous push and pop SHALL both complete; level unchanged; push when full SHALL not occur (src_ready=0); pop when empty SHALL not occur.
REQ-024 Push into empty buffer SHALL be poppable the following cycle (no bypass).
REQ-025 dcr[i] while pending[i] already set SHALL be absorbed (one refresh).
REQ-026 underrun SHALL set when any dcr bit is 1 and level==0; cleared only by reset.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; level SHALL reach DEPTH exactly when full.

Reset
REQ-028 On rst_n low: all trng_a_out/trng_d_out zero, upd=0, pending=0, level=0, underrun=0, pointers=0, src_ready=0 while rst_n low.
REQ-029 Reset mid-operation SHALL discard buffered pairs and pending requests; outputs zero immediately (asynchronous).
REQ-030 First cycle after release src_ready SHALL be 1.

Configuration
REQ-031 Macro TRNG_REPEAT_CHECK_EN defined: an accepted pair whose {a,d} equals the previously accepted pair SHALL be dropped (not written) and a 1-bit sticky output rep_fail SHALL set; src_ready behaviour unchanged.
REQ-032 Macro undefined: no comparison, all accepted pairs written, rep_fail port absent.

Structure
REQ-033 Shared package trng_pkg SHALL hold default width/depth/channel constants and the {a,d} pair packed typedef.
REQ-034 Buffer SHALL be a sub-module trng_pair_fifo (push/pop/full/empty/level); arbitration and channel registers in the top.

Verification
REQ-035 Reset, push 3 pairs (A=0x1..3, D=0x11..13), dcr=4'b0001 -> next cycle ch0 A=0x1 D=0x11, upd=4'b0001, level 2.
REQ-036 dcr=4'b1010 with level 2 -> ch1 loaded cycle 1, ch3 loaded cycle 2, pending clears in that order.
REQ-037 Empty buffer, dcr=4'b0100 -> underrun=1, pending[2]=1; push pair 0xA -> ch2 A=0xA two cycles after push.
REQ-038 Fill DEPTH=8 -> src_ready=0, level=8; simultaneous dcr and src_valid -> one pop, level 7, src_ready=1 next cycle.
REQ-039 Assert rst_n low with level 5, pending=4'b0011 -> all outputs zero asynchronously, level 0 after release.
REQ-040 TRNG_REPEAT_CHECK_EN: push identical pair twice -> level 1, rep_fail=1; without macro -> level 2.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared constants and the {a,d} pair type for the TRNG pool manager slice.
package trng_pkg;

    localparam int TRNG_A_W_DEF = 64;
    localparam int TRNG_D_W_DEF = 32;
    localparam int NUM_CH_DEF   = 4;
    localparam int DEPTH_DEF    = 8;

    typedef struct packed {
        logic [TRNG_A_W_DEF-1:0] a;
        logic [TRNG_D_W_DEF-1:0] d;
    } trng_pair_t;

    localparam int TRNG_PAIR_W_DEF = $bits(trng_pair_t);

endpackage

// File: rtl/trng_pair_fifo.sv
// Prefetch buffer for entropy pairs; registered head, no push-to-pop bypass.
module trng_pair_fifo
    import trng_pkg::*;
#(
    parameter int WIDTH = TRNG_PAIR_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == LW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/trng_pool_manager.sv
// Prefetches TRNG {a,d} pairs and hands them to NUM_CH channels, lowest index first.
// Optional TRNG_REPEAT_CHECK_EN drops a pair identical to the previous accepted one.
module trng_pool_manager
    import trng_pkg::*;
#(
    parameter int TRNG_A_WIDTH = TRNG_A_W_DEF,
    parameter int TRNG_D_WIDTH = TRNG_D_W_DEF,
    parameter int NUM_CH       = NUM_CH_DEF,
    parameter int DEPTH        = DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             src_valid,
    input  logic [TRNG_A_WIDTH-1:0]          src_a,
    input  logic [TRNG_D_WIDTH-1:0]          src_d,
    output logic                             src_ready,
    input  logic [NUM_CH-1:0]                dcr,
    output logic [NUM_CH*TRNG_A_WIDTH-1:0]   trng_a_out,
    output logic [NUM_CH*TRNG_D_WIDTH-1:0]   trng_d_out,
    output logic [NUM_CH-1:0]                upd,
    output logic [NUM_CH-1:0]                pending,
    output logic [$clog2(DEPTH):0]           level,
    output logic                             underrun
`ifdef TRNG_REPEAT_CHECK_EN
   ,output logic                             rep_fail
`endif
);

    localparam int PW = TRNG_A_WIDTH + TRNG_D_WIDTH;
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [TRNG_A_WIDTH-1:0] a;
        logic [TRNG_D_WIDTH-1:0] d;
    } pair_w_t;

    pair_w_t         in_pair, head;
    logic            full, empty, accept, push, pop;
    logic [LW-1:0]   fifo_level;
    logic [NUM_CH-1:0] pending_q, pending_d, upd_q, req, grant;
    logic            underrun_q, underrun_d;
    logic            found;

    assign in_pair.a = src_a;
    assign in_pair.d = src_d;

    // Held low during reset so no pair is offered to a buffer being cleared.
    assign src_ready = rst_n && !full;
    assign accept    = src_valid && src_ready;

`ifdef TRNG_REPEAT_CHECK_EN
    pair_w_t prev_q;
    logic    prev_vld_q, rep_fail_q, dup;

    assign dup      = prev_vld_q && (in_pair == prev_q);
    assign push     = accept && !dup;
    assign rep_fail = rep_fail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            rep_fail_q <= 1'b0;
        end else if (accept) begin
            prev_q     <= in_pair;
            prev_vld_q <= 1'b1;
            if (dup) rep_fail_q <= 1'b1;
        end
    end
`else
    assign push = accept;
`endif

    trng_pair_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (in_pair),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Same-cycle dcr competes alongside already-pending requests.
    always_comb begin
        req   = pending_q | dcr;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && !found && !empty) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        pop        = found;
        pending_d  = req & ~grant;
        underrun_d = underrun_q | ((|dcr) && empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            upd_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            upd_q      <= grant;
            underrun_q <= underrun_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [TRNG_A_WIDTH-1:0] a_q;
        logic [TRNG_D_WIDTH-1:0] d_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                d_q <= '0;
            end else if (grant[g]) begin
                a_q <= head.a;
                d_q <= head.d;
            end
        end

        assign trng_a_out[g*TRNG_A_WIDTH +: TRNG_A_WIDTH] = a_q;
        assign trng_d_out[g*TRNG_D_WIDTH +: TRNG_D_WIDTH] = d_q;
    end

    assign upd      = upd_q;
    assign pending  = pending_q;
    assign level    = fifo_level;
    assign underrun = underrun_q;

endmodule
